// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, a carry flip-flop and shift registers.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf_o.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf_o
`endif
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               done_q, done_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               fa_sum, fa_cout, last;
`ifdef SERIAL_ADDER_OVF_EN
  logic               ovf_cap_q, ovf_cap_d;
  logic               ovf_q, ovf_d;
`endif

  // Full-adder cell fed by the operand LSBs and the registered carry.
  assign fa_sum  = a_q[0] ^ b_q[0] ^ carry_q;
  assign fa_cout = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
  assign last    = (cnt_q == CntW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_cap_d = ovf_cap_q;
    ovf_d     = ovf_q;
`endif
    case (state_q)
      StIdle: begin
        if (start_i) begin
          a_d     = a_i;
          b_d     = b_i;
          carry_d = cin_i;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        carry_d = fa_cout;
        res_d   = {fa_sum, res_q[WIDTH-1:1]};
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        if (last) begin
          state_d = StDone;
`ifdef SERIAL_ADDER_OVF_EN
          // carry_q is the carry into the MSB, fa_cout the carry out of it.
          ovf_cap_d = carry_q ^ fa_cout;
`endif
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        sum_d   = res_q;
        cout_d  = carry_q;
        done_d  = 1'b1;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_cap_q;
`endif
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      sum_q     <= '0;
      carry_q   <= 1'b0;
      cout_q    <= 1'b0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_cap_q <= 1'b0;
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      sum_q     <= sum_d;
      carry_q   <= carry_d;
      cout_q    <= cout_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_cap_q <= ovf_cap_d;
      ovf_q     <= ovf_d;
`endif
    end
  end

  assign busy_o = (state_q != StIdle);
  assign done_o = done_q;
  assign sum_o  = sum_q;
  assign cout_o = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf_o  = ovf_q;
`endif

endmodule
